nios2_mulx_seq: RTL

- Sequential 32x32 multiply unit for the Nios II core.
- Produces the low word (mul) or the high word (mulxuu/mulxss/mulxsu) of the 64-bit product.
- Uses one pipelined 16x16 unsigned partial-product multiplier, issued four times per operation.
- Sits beside the A-stage single-cycle mul cell; it consumes the same src1/src2 operands and supplies the high-word results that cell cannot produce.

---
 rtl/nios2_mulx_seq_pkg.sv | 37 +++
 rtl/nios2_mulx_pp16.sv | 41 ++++
 rtl/nios2_mulx_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/nios2_mulx_seq_pkg.sv
// ============================================================================
// nios2_mulx_seq_pkg
// Shared op encoding, FSM states and partial-product helpers for the
// sequential multiply unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nios2_mulx_seq_pkg;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSS = 2'd2;
  localparam logic [1:0] OP_MULXSU = 2'd3;

  localparam int PP_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CORR  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Partial products are issued lo*lo, hi*lo, lo*hi, hi*hi.
  function automatic logic [5:0] pp_shift(input logic [1:0] tag);
    case (tag)
      2'd0:    return 6'd0;
      2'd3:    return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/nios2_mulx_pp16.sv
// ============================================================================
// nios2_mulx_pp16
// Registered 16x16 unsigned multiplier, LATENCY register stages, no enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nios2_mulx_pp16 #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);

  logic [31:0] w_prod;
  logic [31:0] r_pipe [LATENCY];

  assign w_prod = {16'd0, i_a} * {16'd0, i_b};

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe[g] <= '0;
        else     r_pipe[g] <= w_prod;
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pipe[g] <= '0;
        else     r_pipe[g] <= r_pipe[g-1];
      end
    end
  end

  assign o_p = r_pipe[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/nios2_mulx_seq.sv
// ============================================================================
// nios2_mulx_seq
// Sequential 32x32 multiplier returning the low (mul) or high (mulx*) word,
// built from four issues of one pipelined 16x16 unsigned multiplier.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nios2_mulx_seq
  import nios2_mulx_seq_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t                 r_state;
  logic [1:0]             r_op;
  logic [31:0]            r_src1;
  logic [31:0]            r_src2;
  logic [1:0]             r_cnt;
  logic [63:0]            r_acc;
  logic                   r_busy;
  logic                   r_done;
  logic [31:0]            r_result;
  logic [MUL_LATENCY-1:0] r_vld;
  logic [1:0]             r_tag [MUL_LATENCY];

  logic [15:0] w_mul_a;
  logic [15:0] w_mul_b;
  logic [31:0] w_pp;
  logic        w_pp_vld;
  logic [1:0]  w_pp_tag;
  logic [63:0] w_pp_term;
  logic [31:0] w_corr1;
  logic [31:0] w_corr2;
  logic [31:0] w_hi_corr;

  // Counter bit 0 picks the src1 half, bit 1 the src2 half.
  assign w_mul_a = r_cnt[0] ? r_src1[31:16] : r_src1[15:0];
  assign w_mul_b = r_cnt[1] ? r_src2[31:16] : r_src2[15:0];

  nios2_mulx_pp16 #(
    .LATENCY (MUL_LATENCY)
  ) u_pp16 (
    .clk (clk),
    .rst (reset),
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_pp)
  );

  assign w_pp_vld  = r_vld[MUL_LATENCY-1];
  assign w_pp_tag  = r_tag[MUL_LATENCY-1];
  assign w_pp_term = {32'd0, w_pp} << pp_shift(w_pp_tag);

  // Signed fix-up of the unsigned high word: subtract the other operand
  // for every operand whose sign bit carries weight -2^31.
  assign w_corr1   = ((r_op == OP_MULXSS || r_op == OP_MULXSU) && r_src1[31]) ? r_src2 : 32'd0;
  assign w_corr2   = ((r_op == OP_MULXSS) && r_src2[31]) ? r_src1 : 32'd0;
  assign w_hi_corr = r_acc[63:32] - w_corr1 - w_corr2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_vld    <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_vld[0] <= (r_state == ST_ISSUE);
      r_tag[0] <= r_cnt;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      if (w_pp_vld) r_acc <= r_acc + w_pp_term;

      if (flush && r_state != ST_IDLE) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_vld   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_op    <= op;
              r_src1  <= src1;
              r_src2  <= src2;
              r_cnt   <= '0;
              r_acc   <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'(PP_COUNT - 1)) r_state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (w_pp_vld && w_pp_tag == 2'(PP_COUNT - 1)) r_state <= ST_CORR;
          end
          ST_CORR: begin
            r_result <= (r_op == OP_MUL) ? r_acc[31:0] : w_hi_corr;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
          ST_DONE: begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

`default_nettype wire
